bridge_ctrl: RTL and testbench
==============================

// Module: bridge_ctrl
// PURPOSE
//  Parametrised CPU-to-peripheral bridge for the MIPS SoC, the successor of the two-timer bridge.
//  Decodes N_DEV equal-stride device windows and gates per-device write enables.
//  Returns registered read data with a ready pulse and flags bus errors on unmapped accesses.
//  Aggregates device IRQs through a bridge-local mask register into HWInt for CP0.
// PARAMETERS
//  N_DEV     2              number of device slots, 1..6
//  BASE      32'h0000_7F00  byte address of slot 0
//  STRIDE    32'h0000_0010  byte distance between slot bases; power of two, >= WIN_BYTES
//  WIN_BYTES 12             bytes decoded per slot (word offsets 0..WIN_BYTES-4)
// PORTS
//  clk      in   1         system clock, rising edge
//  reset    in   1         synchronous, active-high
//  PrAddr   in   32        CPU byte address; bits[1:0] ignored
//  PrWD     in   32        CPU write data
//  PrWE     in   1         CPU write strobe
//  PrRE     in   1         CPU read strobe
//  PrRD     out  32        registered read data
//  PrRdy    out  1         1-cycle pulse: PrRD valid for the previous cycle's read
//  BusErr   out  1         1-cycle pulse: previous cycle's access hit no slot or register
//  Dev_Addr out  32        PrAddr passed through
//  Dev_WD   out  32        PrWD passed through
//  Dev_WE   out  N_DEV     one-hot write enable, combinational
//  Dev_RD   in   32*N_DEV  device i read data at bits [32*i+31:32*i]
//  Dev_IRQ  in   N_DEV     device interrupt requests, level
//  HWInt    out  6         {0..., Dev_IRQ & mask}, registered
// BEHAVIOUR
//  - Slot i hit: BASE+i*STRIDE <= PrAddr <= BASE+i*STRIDE+WIN_BYTES-1. At most one slot hits.
//  - MASK_ADDR = BASE+N_DEV*STRIDE. Reads return {26'b0, mask}; bits above N_DEV are 0.
//  - Dev_WE[i] = hit_i & PrWE in the same cycle, no latency. PrWE to MASK_ADDR loads mask at the edge.
//  - Read with PrRE=1 at edge k:
//    - rd_q captures the hit slot's Dev_RD slice, or the register value.
//    - PrRD = rd_q and PrRdy = 1 during cycle k+1. PrRdy stays 0 when PrRE=0.
//    - PrRD holds its last value while idle.
//  - Unmapped access (PrWE or PrRE with no hit):
//    - Dev_WE = 0 and the write is dropped.
//    - Next cycle: BusErr = 1, and PrRdy = 1 with PrRD = 0 if the access was a read.
//  - PrWE and PrRE together on one address: the read returns the pre-write value; the write completes.
//  - Back-to-back reads: one result per cycle, no stall.
//  - HWInt[N_DEV-1:0] <= Dev_IRQ & mask each cycle (1-cycle latency). HWInt[5:N_DEV] are always 0.
//  - Reset (any cycle, including a read in flight):
//    - PrRD = 0, PrRdy = 0, BusErr = 0, HWInt = 0.
//    - mask = all ones, so the default routing is unmasked.
//    - A read pending at the reset edge produces no PrRdy.
// CONFIGURATION
//  BRIDGE_ERRLOG_EN defined:
//    - ERR_ADDR register at MASK_ADDR+4.
//    - On the first unmapped access while errv = 0, latch {PrAddr[31:2], PrWE, 1'b1} and set errv.
//    - A read of ERR_ADDR returns the value (0 when errv = 0), then clears it and errv next edge.
//    - An error that coincides with the clearing read is latched.
//    - Writes to ERR_ADDR are ignored without BusErr.
//    - Reset clears ERR_ADDR and errv.
//  BRIDGE_ERRLOG_EN undefined:
//    - MASK_ADDR+4 is unmapped and raises BusErr.
//    - No error storage.
// TESTING (N_DEV=2 defaults unless noted)
//  - PrWE=1, PrAddr=0x7F04 -> Dev_WE=2'b01 same cycle. PrAddr=0x7F18 -> Dev_WE=2'b10. PrAddr=0x7F0C -> Dev_WE=0, BusErr next cycle.
//  - PrRE=1, PrAddr=0x7F14, Dev_RD[63:32]=0xAABB_CCDD -> next cycle PrRD=0xAABB_CCDD, PrRdy=1. Reads of 0x7F00 then 0x7F10 on consecutive cycles -> two consecutive PrRdy.
//  - Write 0x2 to 0x7F20, Dev_IRQ=2'b11 -> HWInt=6'b000010 one cycle later. Read of 0x7F20 -> PrRD=0x2.
//  - Reset asserted the cycle after PrRE -> PrRdy=0, HWInt=0. Read of 0x7F20 after reset -> 0x3.
//  - ERRLOG_EN: write to 0x7F30, then read 0x7F24 -> PrRD=0x0000_7F33. Second read of 0x7F24 -> 0.
//  - N_DEV=6, STRIDE=0x20: read 0x7FA8 -> slot 5 data returned. HWInt[5:0] follows Dev_IRQ & mask.

Source files
------------

// File: rtl/bridge_ctrl.sv
// CPU-to-peripheral bridge: N_DEV equal-stride device windows, IRQ mask register, registered reads.
// Optional error-address log at MASK_ADDR+4 when BRIDGE_ERRLOG_EN is defined.
module bridge_ctrl #(
    parameter int          N_DEV     = 2,
    parameter logic [31:0] BASE      = 32'h0000_7F00,
    parameter logic [31:0] STRIDE    = 32'h0000_0010,
    parameter int          WIN_BYTES = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          PrAddr,
    input  logic [31:0]          PrWD,
    input  logic                 PrWE,
    input  logic                 PrRE,
    output logic [31:0]          PrRD,
    output logic                 PrRdy,
    output logic                 BusErr,
    output logic [31:0]          Dev_Addr,
    output logic [31:0]          Dev_WD,
    output logic [N_DEV-1:0]     Dev_WE,
    input  logic [32*N_DEV-1:0]  Dev_RD,
    input  logic [N_DEV-1:0]     Dev_IRQ,
    output logic [5:0]           HWInt
);

    localparam logic [31:0] MASK_ADDR = BASE + STRIDE * 32'(N_DEV);
    localparam logic [31:0] ERR_ADDR  = MASK_ADDR + 32'd4;

    // Valid/ready: a strobe (PrWE/PrRE) is accepted every cycle with no stall;
    // reads answer with a one-cycle PrRdy pulse one cycle later, unmapped
    // accesses answer with a one-cycle BusErr pulse one cycle later.

    logic [31:0]      w_addr;
    logic [N_DEV-1:0] w_slot_hit;
    logic [31:0]      w_slot_rd;
    logic             w_mask_hit;
    logic             w_err_hit;
    logic             w_mapped;
    logic             w_unmapped;
    logic [31:0]      w_rd_next;
    logic [5:0]       w_hwint_next;

    logic [31:0]      r_rd_q;
    logic             r_rdy;
    logic             r_buserr;
    logic [5:0]       r_hwint;
    logic [N_DEV-1:0] r_mask;
    logic [31:0]      r_err_addr;
    logic             r_errv;

    assign w_addr = {PrAddr[31:2], 2'b00};

    // Wrapping subtraction keeps the window test correct even when BASE is 0.
    for (genvar g = 0; g < N_DEV; g++) begin : g_slot
        localparam logic [31:0] SLOT_LO = BASE + STRIDE * 32'(g);
        assign w_slot_hit[g] = ((w_addr - SLOT_LO) < 32'(WIN_BYTES));
    end

    always_comb begin
        w_slot_rd = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (w_slot_hit[i]) begin
                w_slot_rd = Dev_RD[32*i +: 32];
            end
        end
    end

    assign w_mask_hit = (w_addr == MASK_ADDR);

`ifdef BRIDGE_ERRLOG_EN
    assign w_err_hit = (w_addr == ERR_ADDR);
`else
    assign w_err_hit = 1'b0;
`endif

    assign w_mapped   = (|w_slot_hit) | w_mask_hit | w_err_hit;
    assign w_unmapped = (PrWE | PrRE) & ~w_mapped;

    assign Dev_Addr = PrAddr;
    assign Dev_WD   = PrWD;
    assign Dev_WE   = PrWE ? w_slot_hit : '0;

    // Register reads see the pre-write value, so a simultaneous write is invisible to them.
    always_comb begin
        w_rd_next = '0;
        if (|w_slot_hit) begin
            w_rd_next = w_slot_rd;
        end else if (w_mask_hit) begin
            w_rd_next[N_DEV-1:0] = r_mask;
        end else if (w_err_hit) begin
            w_rd_next = r_err_addr;
        end
    end

    always_comb begin
        w_hwint_next = '0;
        w_hwint_next[N_DEV-1:0] = Dev_IRQ & r_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_q   <= '0;
            r_rdy    <= 1'b0;
            r_buserr <= 1'b0;
            r_hwint  <= '0;
            r_mask   <= '1;
        end else begin
            r_rdy    <= PrRE;
            r_buserr <= w_unmapped;
            r_hwint  <= w_hwint_next;
            if (PrRE) begin
                r_rd_q <= w_rd_next;
            end
            if (PrWE && w_mask_hit) begin
                r_mask <= PrWD[N_DEV-1:0];
            end
        end
    end

`ifdef BRIDGE_ERRLOG_EN
    // A fresh error wins over the clearing read so no fault is ever lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_addr <= '0;
            r_errv     <= 1'b0;
        end else if (w_unmapped && (!r_errv || (PrRE && w_err_hit))) begin
            r_err_addr <= {PrAddr[31:2], PrWE, 1'b1};
            r_errv     <= 1'b1;
        end else if (PrRE && w_err_hit) begin
            r_err_addr <= '0;
            r_errv     <= 1'b0;
        end
    end
`else
    assign r_err_addr = '0;
    assign r_errv     = 1'b0;
`endif

    assign PrRD   = r_rd_q;
    assign PrRdy  = r_rdy;
    assign BusErr = r_buserr;
    assign HWInt  = r_hwint;

endmodule

// File: tb/tb_bridge_ctrl.sv
// Scoreboard bench for bridge_ctrl: driver feeds a high-level address-map model,
// monitor pops expected responses when the bridge presents PrRdy/BusErr.
module tb_bridge_ctrl;

  localparam int          N_DEV     = 2;
  localparam logic [31:0] BASE      = 32'h0000_7F00;
  localparam logic [31:0] STRIDE    = 32'h0000_0010;
  localparam int          WIN_BYTES = 12;

  logic                 clk;
  logic                 reset;
  logic [31:0]          PrAddr;
  logic [31:0]          PrWD;
  logic                 PrWE;
  logic                 PrRE;
  logic [31:0]          PrRD;
  logic                 PrRdy;
  logic                 BusErr;
  logic [31:0]          Dev_Addr;
  logic [31:0]          Dev_WD;
  logic [N_DEV-1:0]     Dev_WE;
  logic [32*N_DEV-1:0]  Dev_RD;
  logic [N_DEV-1:0]     Dev_IRQ;
  logic [5:0]           HWInt;

  bridge_ctrl #(
    .N_DEV(N_DEV), .BASE(BASE), .STRIDE(STRIDE), .WIN_BYTES(WIN_BYTES)
  ) dut (
    .clk(clk), .reset(reset), .PrAddr(PrAddr), .PrWD(PrWD), .PrWE(PrWE), .PrRE(PrRE),
    .PrRD(PrRD), .PrRdy(PrRdy), .BusErr(BusErr), .Dev_Addr(Dev_Addr), .Dev_WD(Dev_WD),
    .Dev_WE(Dev_WE), .Dev_RD(Dev_RD), .Dev_IRQ(Dev_IRQ), .HWInt(HWInt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // per-cycle expectations: {HWInt[5:0], PrRD[31:0]}
  logic [37:0] cyc_q[$];
  // per-response expectations: {rdy, err, data[31:0]}
  logic [33:0] exp_q[$];

  // reference model state
  logic [N_DEV-1:0] m_mask;
  logic [31:0]      m_prrd;
  bit               m_errv;
  logic [31:0]      m_errval;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Address map from arithmetic on the offset from BASE.
  task automatic decode(input logic [31:0] addr, output int slot, output bit is_mask, output bit is_err);
    longint a, off, mask_a;
    a      = longint'(addr & 32'hFFFF_FFFC);
    mask_a = longint'(BASE) + longint'(N_DEV) * longint'(STRIDE);
    slot    = -1;
    is_mask = (a == mask_a);
    is_err  = (a == mask_a + 4);
    if (a >= longint'(BASE)) begin
      off = a - longint'(BASE);
      if (off < longint'(N_DEV) * longint'(STRIDE) && (off % longint'(STRIDE)) < longint'(WIN_BYTES))
        slot = int'(off / longint'(STRIDE));
    end
  endtask

  task automatic drive(input bit rst, input bit we, input bit re, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [N_DEV-1:0] irq,
                       input logic [32*N_DEV-1:0] rdv);
    int slot;
    bit is_mask, is_err, mapped;
    logic [N_DEV-1:0] exp_we;
    logic [5:0] hw;
    logic [31:0] val;
    @(negedge clk);
    reset = rst; PrWE = we; PrRE = re; PrAddr = addr; PrWD = wd; Dev_IRQ = irq; Dev_RD = rdv;
    #1;
    decode(addr, slot, is_mask, is_err);
    exp_we = '0;
    if (we && slot >= 0) exp_we[slot] = 1'b1;
    check("dev_we", 64'(Dev_WE), 64'(exp_we));
    check("passthru", {Dev_Addr, Dev_WD}, {addr, wd});
`ifdef BRIDGE_ERRLOG_EN
    mapped = (slot >= 0) || is_mask || is_err;
`else
    mapped = (slot >= 0) || is_mask;
    is_err = 1'b0;
`endif
    if (rst) begin
      m_mask = '1; m_prrd = '0; m_errv = 0; m_errval = '0;
      cyc_q.push_back({6'b0, 32'b0});
    end else begin
      hw = '0;
      hw[N_DEV-1:0] = irq & m_mask;
      val = '0;
      if (slot >= 0)    val = rdv[32*slot +: 32];
      else if (is_mask) val[N_DEV-1:0] = m_mask;
      else if (is_err)  val = m_errval;
      if (re) m_prrd = val;
      if (re || (we && !mapped)) exp_q.push_back({re, !mapped, re ? val : 32'b0});
      if ((we || re) && !mapped && !m_errv) begin
        m_errval = {addr[31:2], we, 1'b1};
        m_errv = 1;
      end else if (re && is_err) begin
        m_errval = '0;
        m_errv = 0;
      end
      if (we && is_mask) m_mask = wd[N_DEV-1:0];
      cyc_q.push_back({hw, m_prrd});
    end
  endtask

  task automatic idle(input logic [N_DEV-1:0] irq);
    drive(0, 0, 0, 32'h0, 32'h0, irq, {$urandom, $urandom});
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0, 1, 2: a = BASE + STRIDE * $urandom_range(0, N_DEV) + 32'(4 * $urandom_range(0, 3));
      3:       a = BASE - 32'(4 * $urandom_range(1, 4));
      4:       a = $urandom;
      default: a = BASE + STRIDE * N_DEV;
    endcase
    return a | 32'($urandom_range(0, 3));
  endfunction

  // monitor: compares away from the active edge
  initial begin
    logic [37:0] c;
    logic [33:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        check("hwint", 64'(HWInt), 64'(c[37:32]));
        check("prrd_reg", 64'(PrRD), 64'(c[31:0]));
      end
      if (PrRdy || BusErr) begin
        if (exp_q.size() == 0) begin
          check("spurious_resp", 64'({PrRdy, BusErr}), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("prrdy", 64'(PrRdy), 64'(e[33]));
          check("buserr", 64'(BusErr), 64'(e[32]));
          if (e[33]) check("prrd_data", 64'(PrRD), 64'(e[31:0]));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; PrWE = 0; PrRE = 0; PrAddr = '0; PrWD = '0; Dev_IRQ = '0; Dev_RD = '0;
    m_mask = '1; m_prrd = '0; m_errv = 0; m_errval = '0;
    repeat (3) drive(1, 0, 0, 32'h0, 32'h0, 2'b11, '0);
    idle(2'b11);
    // window decode and write enables
    drive(0, 1, 0, 32'h7F04, 32'h1234_5678, 2'b00, {$urandom, $urandom});
    drive(0, 1, 0, 32'h7F18, 32'h9ABC_DEF0, 2'b00, {$urandom, $urandom});
    drive(0, 1, 0, 32'h7F0C, 32'h1111_1111, 2'b00, {$urandom, $urandom});
    // reads, including back-to-back
    drive(0, 0, 1, 32'h7F14, 32'h0, 2'b00, {32'hAABB_CCDD, 32'h0102_0304});
    drive(0, 0, 1, 32'h7F00, 32'h0, 2'b00, {32'h5555_0000, 32'hCAFE_F00D});
    drive(0, 0, 1, 32'h7F10, 32'h0, 2'b00, {32'hDEAD_BEEF, 32'h0});
    idle(2'b00);
    // IRQ mask
    drive(0, 1, 0, 32'h7F20, 32'h2, 2'b11, '0);
    idle(2'b11);
    drive(0, 0, 1, 32'h7F20, 32'h0, 2'b11, '0);
    drive(0, 1, 1, 32'h7F20, 32'h1, 2'b11, '0);
    idle(2'b11);
    // reset with a read in flight, then default mask
    drive(1, 0, 1, 32'h7F00, 32'h0, 2'b11, {32'h0, 32'h7777_7777});
    drive(0, 0, 1, 32'h7F20, 32'h0, 2'b11, '0);
    drive(0, 0, 1, 32'h7F24, 32'h0, 2'b11, '0);
`ifdef BRIDGE_ERRLOG_EN
    drive(0, 1, 0, 32'h7F30, 32'h0, 2'b00, '0);
    drive(0, 0, 1, 32'h7F24, 32'h0, 2'b00, '0);
    drive(0, 0, 1, 32'h7F24, 32'h0, 2'b00, '0);
    drive(0, 1, 0, 32'h7F24, 32'h5, 2'b00, '0);
`endif
    idle(2'b01);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 2), 1'($urandom), 1'($urandom), rand_addr(), $urandom,
            N_DEV'($urandom), {$urandom, $urandom});
    end
    repeat (3) idle('0);
    @(negedge clk);
    check("resp_drain", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
